// File: rtl/shift_seq_pkg.sv
// Shared definitions for the shift sequencer: FSM state encoding and the
// divider width used when SHIFT_SEQUENCER_DIV_EN is defined.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam int DIV_W = 8;

endpackage : shift_seq_pkg

// File: rtl/shift_bit_counter.sv
// Shift-position counter for the shift sequencer. Counts 0..DEPTH-1 on the
// increment strobe and flags the last position. When SHIFT_SEQUENCER_DIV_EN
// is defined it also owns the divider down-counter that paces the shifts.
module shift_bit_counter
  import shift_seq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear_i,
  input  logic             inc_i,
`ifdef SHIFT_SEQUENCER_DIV_EN
  input  logic             active_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o,
`endif
  output logic             last_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next shift position: restart on a new word, step on each shift.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (inc_i) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Shift position register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == CNT_W'(DEPTH - 1));

`ifdef SHIFT_SEQUENCER_DIV_EN
  logic [DIV_W-1:0] div_val_q;
  logic [DIV_W-1:0] div_val_d;
  logic [DIV_W-1:0] div_cnt_q;
  logic [DIV_W-1:0] div_cnt_d;

  // Divider: first pulse right after accept (count starts at 0), then reload
  // with the sampled divisor after every pulse and count down to the next one.
  always_comb begin
    div_val_d = div_val_q;
    div_cnt_d = div_cnt_q;
    if (clear_i) begin
      div_val_d = div_i;
      div_cnt_d = {DIV_W{1'b0}};
    end else if (inc_i) begin
      div_cnt_d = div_val_q;
    end else if (active_i && (div_cnt_q != {DIV_W{1'b0}})) begin
      div_cnt_d = div_cnt_q - {{(DIV_W-1){1'b0}}, 1'b1};
    end else begin
      div_cnt_d = div_cnt_q;
    end
  end

  // Divider registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_val_q <= {DIV_W{1'b0}};
      div_cnt_q <= {DIV_W{1'b0}};
    end else begin
      div_val_q <= div_val_d;
      div_cnt_q <= div_cnt_d;
    end
  end

  assign tick_o = (div_cnt_q == {DIV_W{1'b0}});
`endif

endmodule : shift_bit_counter

// File: rtl/shift_sequencer.sv
// Shift sequencer: turns a DEPTH-deep serial shift register channel into a
// full-duplex word port. A word accepted on start_valid/start_ready is
// shifted out on sr_in over DEPTH enabled cycles while sr_out is captured;
// the captured word is returned on rx_valid/rx_ready.
// Optional macro SHIFT_SEQUENCER_DIV_EN adds the div input, which spaces
// the shift enables div+1 cycles apart.
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [DEPTH-1:0] tx_data,
  input  logic             msb_first,
`ifdef SHIFT_SEQUENCER_DIV_EN
  input  logic [DIV_W-1:0] div,
`endif
  output logic             sr_enable,
  output logic             sr_in,
  input  logic             sr_out,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic [DEPTH-1:0] rx_data,
  output logic             busy
);

  state_e           state_q;
  state_e           state_d;
  logic [DEPTH-1:0] tx_q;
  logic [DEPTH-1:0] tx_d;
  logic [DEPTH-1:0] rx_sh_q;
  logic [DEPTH-1:0] rx_sh_d;
  logic [DEPTH-1:0] rx_data_q;
  logic [DEPTH-1:0] rx_data_d;
  logic             msb_q;
  logic             msb_d;
  logic             accept_s;
  logic             shift_s;
  logic             last_s;
  logic             tick_s;

  assign accept_s = (state_q == IDLE) && start_valid;
  assign shift_s  = (state_q == SHIFT) && tick_s;

  shift_bit_counter #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_counter (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear_i  (accept_s),
    .inc_i    (shift_s),
`ifdef SHIFT_SEQUENCER_DIV_EN
    .active_i (state_q == SHIFT),
    .div_i    (div),
    .tick_o   (tick_s),
`endif
    .last_o   (last_s)
  );

`ifndef SHIFT_SEQUENCER_DIV_EN
  assign tick_s = 1'b1;
`endif

  // Next-state logic for the IDLE -> SHIFT -> HOLD -> IDLE sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_valid) begin
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (shift_s && last_s) begin
          state_d = HOLD;
        end else begin
          state_d = SHIFT;
        end
      end
      HOLD: begin
        if (rx_ready) begin
          state_d = IDLE;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath next values: load on accept, shift tx/rx on each enabled
  // cycle, and publish the rx word on the final shift.
  always_comb begin
    tx_d      = tx_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    msb_d     = msb_q;
    if (accept_s) begin
      tx_d    = tx_data;
      msb_d   = msb_first;
      rx_sh_d = {DEPTH{1'b0}};
    end else if (shift_s) begin
      if (msb_q) begin
        tx_d    = {tx_q[DEPTH-2:0], 1'b0};
        rx_sh_d = {rx_sh_q[DEPTH-2:0], sr_out};
      end else begin
        tx_d    = {1'b0, tx_q[DEPTH-1:1]};
        rx_sh_d = {sr_out, rx_sh_q[DEPTH-1:1]};
      end
      if (last_s) begin
        rx_data_d = rx_sh_d;
      end else begin
        rx_data_d = rx_data_q;
      end
    end else begin
      tx_d = tx_q;
    end
  end

  // State and datapath registers; reset aborts any word in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      tx_q      <= {DEPTH{1'b0}};
      rx_sh_q   <= {DEPTH{1'b0}};
      rx_data_q <= {DEPTH{1'b0}};
      msb_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      msb_q     <= msb_d;
    end
  end

  // Outputs are pure decodes of registered state, so nothing on the shift
  // register side depends combinationally on any input.
  assign start_ready = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign rx_valid    = (state_q == HOLD);
  assign sr_enable   = shift_s;
  assign sr_in       = (state_q == SHIFT) && (msb_q ? tx_q[DEPTH-1] : tx_q[0]);
  assign rx_data     = rx_data_q;

endmodule : shift_sequencer

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer (DEPTH=8) wired to an 8-deep left shift
// register that clears on reset. Table of directed words plus hand-written
// sequences for HOLD back-pressure, mid-shift reset and (when
// SHIFT_SEQUENCER_DIV_EN is defined) the divided shift rate.
module tb_shift_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start_valid = 1'b0;
  logic       start_ready;
  logic [7:0] tx_data = 8'h00;
  logic       msb_first = 1'b0;
  logic       sr_enable;
  logic       sr_in;
  logic       sr_out;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       busy;
`ifdef SHIFT_SEQUENCER_DIV_EN
  logic [7:0] div = 8'd0;
`endif

  int n_vec = 0;
  int n_err = 0;

  shift_sequencer #(.DEPTH(8)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .tx_data     (tx_data),
    .msb_first   (msb_first),
`ifdef SHIFT_SEQUENCER_DIV_EN
    .div         (div),
`endif
    .sr_enable   (sr_enable),
    .sr_in       (sr_in),
    .sr_out      (sr_out),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .rx_data     (rx_data),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Attached 8-deep shift register: first bit in is first bit out.
  logic [7:0] sreg;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) sreg <= 8'h00;
    else if (sr_enable) sreg <= {sreg[6:0], sr_in};
  end
  assign sr_out = sreg[7];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [7:0] tx;
    logic       msb;
    logic [7:0] serial;   // expected sr_in order, bit 7 first
    logic [7:0] exp_rx;
  } vec_t;

  vec_t vecs[7];

  // Send one word at div=0 and check sr_in/sr_enable per cycle, then the
  // result; optionally completes the rx handshake.
  task automatic run_word(input vec_t v, input bit handshake);
    @(negedge clk);
    check("start_ready_idle", {7'd0, start_ready}, 8'd1);
    start_valid = 1'b1;
    tx_data     = v.tx;
    msb_first   = v.msb;
    @(negedge clk);
    start_valid = 1'b0;
    tx_data     = 8'h00;
    for (int i = 0; i < 8; i++) begin
      check("sr_enable_shift", {7'd0, sr_enable}, 8'd1);
      check("sr_in", {7'd0, sr_in}, {7'd0, v.serial[7-i]});
      check("start_ready_busy", {7'd0, start_ready}, 8'd0);
      @(negedge clk);
    end
    check("sr_enable_hold", {7'd0, sr_enable}, 8'd0);
    check("rx_valid", {7'd0, rx_valid}, 8'd1);
    check("rx_data", rx_data, v.exp_rx);
    if (handshake) begin
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
      check("rx_valid_drop", {7'd0, rx_valid}, 8'd0);
      check("start_ready_back", {7'd0, start_ready}, 8'd1);
    end
  endtask

  initial begin
    vecs[0] = '{tx: 8'hA5, msb: 1'b1, serial: 8'hA5, exp_rx: 8'h00};
    vecs[1] = '{tx: 8'h3C, msb: 1'b1, serial: 8'h3C, exp_rx: 8'hA5};
    vecs[2] = '{tx: 8'h01, msb: 1'b0, serial: 8'h80, exp_rx: 8'h3C};
    vecs[3] = '{tx: 8'h80, msb: 1'b0, serial: 8'h01, exp_rx: 8'h01};
    vecs[4] = '{tx: 8'hC3, msb: 1'b1, serial: 8'hC3, exp_rx: 8'h01};
    vecs[5] = '{tx: 8'h12, msb: 1'b0, serial: 8'h48, exp_rx: 8'hC3};
    vecs[6] = '{tx: 8'h96, msb: 1'b1, serial: 8'h96, exp_rx: 8'h48};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_start_ready", {7'd0, start_ready}, 8'd1);
    check("rst_busy", {7'd0, busy}, 8'd0);
    check("rst_rx_valid", {7'd0, rx_valid}, 8'd0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_sr_enable", {7'd0, sr_enable}, 8'd0);
    check("rst_sr_in", {7'd0, sr_in}, 8'd0);
    reset_n = 1'b1;

    foreach (vecs[k]) run_word(vecs[k], 1'b1);

    // HOLD back-pressure: result of 0x96 stays put for 5 cycles
    run_word('{tx: 8'h00, msb: 1'b1, serial: 8'h00, exp_rx: 8'h96}, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_rx_valid", {7'd0, rx_valid}, 8'd1);
      check("hold_rx_data", rx_data, 8'h96);
      check("hold_start_ready", {7'd0, start_ready}, 8'd0);
      check("hold_sr_enable", {7'd0, sr_enable}, 8'd0);
      check("hold_busy", {7'd0, busy}, 8'd1);
    end
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    check("hold_release_ready", {7'd0, start_ready}, 8'd1);
    check("hold_release_valid", {7'd0, rx_valid}, 8'd0);

    // Mid-shift reset after the 4th shift
    start_valid = 1'b1;
    tx_data     = 8'hFF;
    msb_first   = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_rst_sr_enable", {7'd0, sr_enable}, 8'd1);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_sr_enable", {7'd0, sr_enable}, 8'd0);
    check("async_rst_busy", {7'd0, busy}, 8'd0);
    check("async_rst_rx_valid", {7'd0, rx_valid}, 8'd0);
    check("async_rst_start_ready", {7'd0, start_ready}, 8'd1);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("post_rst_no_valid", {7'd0, rx_valid}, 8'd0);
      check("post_rst_ready", {7'd0, start_ready}, 8'd1);
    end
    run_word('{tx: 8'h81, msb: 1'b1, serial: 8'h81, exp_rx: 8'h00}, 1'b1);

`ifdef SHIFT_SEQUENCER_DIV_EN
    // Divided rate: div=2 gives pulses on cycles 1,4,...,22 and rx_valid on 23
    begin
      logic [7:0] tx_b;
      int         pulses;
      tx_b   = 8'hB4;
      pulses = 0;
      @(negedge clk);
      start_valid = 1'b1;
      tx_data     = tx_b;
      msb_first   = 1'b1;
      div         = 8'd2;
      @(negedge clk);
      start_valid = 1'b0;
      div         = 8'd0;
      for (int c = 1; c <= 22; c++) begin
        check("div_sr_enable", {7'd0, sr_enable}, {7'd0, ((c - 1) % 3) == 0});
        check("div_sr_in", {7'd0, sr_in}, {7'd0, tx_b[7 - ((c - 1) / 3)]});
        check("div_rx_valid_low", {7'd0, rx_valid}, 8'd0);
        if (sr_enable) pulses++;
        @(negedge clk);
      end
      check("div_pulse_count", 8'(pulses), 8'd8);
      check("div_rx_valid", {7'd0, rx_valid}, 8'd1);
      check("div_rx_data", rx_data, 8'h81);
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_shift_sequencer

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
Controller that sequences one DEPTH-deep serial shift register channel as a full-duplex word port. It accepts a parallel word on a valid/ready handshake. It then drives the register's serial input and enable for exactly DEPTH shift cycles, capturing the register's serial output bit on each shift. The word that falls out of the register is returned on a valid/ready result port. It sits between word-level logic and any left/right shift register instance of matching DEPTH.

Parameters:
DEPTH, 8, shift register depth and word width in bits; must be >= 2
CNT_W, $clog2(DEPTH), width of the shift counter; derived, do not override

Ports:
clk  input  1  clock; all state changes on rising edge
reset_n  input  1  asynchronous active-low reset
start_valid  input  1  new word offered
start_ready  output  1  sequencer can accept a word
tx_data  input  DEPTH  word to shift in; sampled on start handshake
msb_first  input  1  bit order; sampled on start handshake; 1 = tx_data[DEPTH-1] first
sr_enable  output  1  enable to the shift register
sr_in  output  1  serial bit to the shift register
sr_out  input  1  serial bit from the shift register
rx_valid  output  1  captured word available
rx_ready  input  1  consumer accepts rx_data
rx_data  output  DEPTH  word captured from sr_out
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (asynchronous, effective immediately, any state):
  - state = IDLE; shift counter = 0; tx/rx shift regs = 0.
  - Outputs: rx_data = 0, rx_valid = 0, sr_enable = 0, sr_in = 0, busy = 0, start_ready = 1.
  - Reset in the middle of a shift aborts the word; no partial rx_valid is raised.
- States: IDLE, SHIFT, HOLD.
- IDLE:
  - start_ready = 1; sr_enable = 0.
  - On start_valid at an edge: latch tx_data and msb_first, counter = 0, go to SHIFT.
- SHIFT:
  - sr_enable = 1 every cycle (see Optional Feature for the divided case).
  - sr_in = current tx bit: MSB-first walks DEPTH-1 down to 0; LSB-first walks 0 up to DEPTH-1.
  - Each enabled edge captures sr_out into rx shift reg bit position: first captured bit lands in rx_data[DEPTH-1] if msb_first, else rx_data[0].
  - Counter increments per shift. On the shift with counter = DEPTH-1: commit the rx word to rx_data and go to HOLD.
- HOLD:
  - rx_valid = 1; sr_enable = 0; start_ready = 0.
  - rx_data is stable until the handshake.
  - On rx_ready at an edge: go to IDLE, rx_valid drops.
- Latency: accept at edge E0 → sr_enable high cycles 1..DEPTH → rx_valid high from cycle DEPTH+1. Minimum word period is DEPTH+2 cycles.
- sr_enable and sr_in are decoded from registered state only; no combinational path from any input.
- start_valid while busy is ignored (not queued); the producer must hold it until start_ready.
- rx_data reflects the register's previous contents (DEPTH-shift delay line); the first word after reset returns 0.

Optional Feature:
- Macro SHIFT_SEQUENCER_DIV_EN.
- Defined:
  - Adds input port div (width 8).
  - div is sampled on the start handshake.
  - In SHIFT, sr_enable pulses for one cycle every div+1 cycles, first pulse on cycle 1 after accept.
  - sr_in is held constant between pulses; capture happens only on pulse edges.
  - div = 0 behaves identically to the undefined build.
- Undefined: port absent; one shift per cycle.

Decomposition:
- Package shift_seq_pkg holds:
  - the state encoding typedef (IDLE = 2'd0, SHIFT = 2'd1, HOLD = 2'd2);
  - the DIV_W = 8 constant.
- One natural sub-module: shift_bit_counter.
  - Counts 0..DEPTH-1 on an increment strobe and flags last.
  - Holds the divider down-counter when SHIFT_SEQUENCER_DIV_EN is defined.

Test Plan:
Bench: DEPTH=8, sequencer wired to an 8-deep shift register that resets to 0.
1. Release reset; start tx_data=8'hA5, msb_first=1 → sr_in = 1,0,1,0,0,1,0,1 on cycles 1..8; sr_enable high exactly 8 cycles; rx_valid on cycle 9 with rx_data=8'h00.
2. Handshake the result; start 8'h3C, msb_first=1 → rx_data=8'hA5.
3. msb_first=0, tx_data=8'h01 → sr_in = 1 then seven 0s; next word with msb_first=0 returns rx_data=8'h01.
4. Hold rx_ready=0 for 5 cycles in HOLD → rx_valid and rx_data stable, start_ready=0, sr_enable=0; raise rx_ready → IDLE and start_ready=1 the next cycle.
5. Assert reset_n low mid-SHIFT after the 4th shift → sr_enable, busy and rx_valid go 0 without waiting for clk; after release start_ready=1 and no stale rx_valid appears.
6. With SHIFT_SEQUENCER_DIV_EN and div=2 → 8 sr_enable pulses spaced 3 cycles apart, rx_valid on cycle 23 after accept; captured word matches the div=0 case.
